// File: rtl/y86_regfile_sb.sv
// Y86-64 register file, two read / two write ports, pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module y86_regfile_sb #(
  parameter int NUM_REGS = 15,
  parameter int DATA_W   = 64,
  parameter int PEND_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 srcA,
  input  logic [3:0]                 srcB,
  output logic [DATA_W-1:0]          valA,
  output logic [DATA_W-1:0]          valB,
  output logic                       hazA,
  output logic                       hazB,
  input  logic                       alloc_valid,
  input  logic [3:0]                 alloc_dstE,
  input  logic [3:0]                 alloc_dstM,
  output logic                       alloc_ready,
  input  logic                       wE_en,
  input  logic                       wM_en,
  input  logic [3:0]                 wE_dst,
  input  logic [3:0]                 wM_dst,
  input  logic [DATA_W-1:0]          wE_data,
  input  logic [DATA_W-1:0]          wM_data,
  output logic [NUM_REGS*DATA_W-1:0] reg_dump
);

  localparam logic [PEND_W-1:0] CMAX = '1;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [PEND_W-1:0] cnt_q  [NUM_REGS];
  logic [PEND_W-1:0] cnt_d  [NUM_REGS];
  logic [1:0]        ndec   [NUM_REGS];
  logic [DATA_W-1:0] rd_val [NUM_REGS];
  logic [NUM_REGS-1:0] hitE, hitM, hitA, full, rd_haz;
  logic alloc_acc;

  function automatic logic [PEND_W-1:0] nxt_cnt(
    input logic [PEND_W-1:0] c,
    input logic              inc,
    input logic [1:0]        dec
  );
    logic [PEND_W+1:0] s;
    logic [PEND_W+1:0] d;
    s = {2'b00, c} + {{(PEND_W+1){1'b0}}, inc};
    d = {{PEND_W{1'b0}}, dec};
    // Decrement below zero is a protocol error; floor instead of wrap
    if (s < d) return '0;
    return PEND_W'(s - d);
  endfunction

  // Out-of-range and RNONE indices never match any register slot
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      hitE[i] = wE_en && (wE_dst == 4'(i));
      hitM[i] = wM_en && (wM_dst == 4'(i));
      hitA[i] = (alloc_dstE == 4'(i)) || (alloc_dstM == 4'(i));
      full[i] = cnt_q[i] == CMAX;
      ndec[i] = {1'b0, hitE[i]} + {1'b0, hitM[i]};
    end
  end

  assign alloc_ready = ~|(hitA & full & ~(hitE | hitM));
  assign alloc_acc   = alloc_valid && alloc_ready;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = hitM[i] ? wM_data
                : hitE[i] ? wE_data
                : regs_q[i];
      cnt_d[i]  = nxt_cnt(cnt_q[i], alloc_acc && hitA[i], ndec[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_BYPASS_EN
      rd_val[i] = regs_d[i];
      rd_haz[i] = {2'b00, cnt_q[i]} > {{PEND_W{1'b0}}, ndec[i]};
`else
      rd_val[i] = regs_q[i];
      rd_haz[i] = |cnt_q[i];
`endif
    end
  end

  always_comb begin
    valA = '0;
    valB = '0;
    hazA = 1'b0;
    hazB = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (srcA == 4'(i)) begin
        valA = rd_val[i];
        hazA = rd_haz[i];
      end
      if (srcB == 4'(i)) begin
        valB = rd_val[i];
        hazB = rd_haz[i];
      end
    end
  end

  always_comb begin
    reg_dump = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_dump[i*DATA_W +: DATA_W] = regs_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_W'(i);
        cnt_q[i]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_y86_regfile_sb.sv
// Bench for y86_regfile_sb: directed scenarios plus random traffic
// against an array-based model of registers and pending counts.
module tb_y86_regfile_sb;

  localparam int NR   = 15;
  localparam int DW   = 64;
  localparam int PW   = 2;
  localparam int CMAX = (1 << PW) - 1;

  logic          clk;
  logic          rst_n;
  logic [3:0]    srcA, srcB;
  logic [DW-1:0] valA, valB;
  logic          hazA, hazB;
  logic          alloc_valid;
  logic [3:0]    alloc_dstE, alloc_dstM;
  logic          alloc_ready;
  logic          wE_en, wM_en;
  logic [3:0]    wE_dst, wM_dst;
  logic [DW-1:0] wE_data, wM_data;
  logic [NR*DW-1:0] reg_dump;

  logic [DW-1:0] mreg [NR];
  int            mcnt [NR];
  int n_vec = 0;
  int n_err = 0;

  y86_regfile_sb #(.NUM_REGS(NR), .DATA_W(DW), .PEND_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB),
    .hazA(hazA), .hazB(hazB),
    .alloc_valid(alloc_valid),
    .alloc_dstE(alloc_dstE), .alloc_dstM(alloc_dstM),
    .alloc_ready(alloc_ready),
    .wE_en(wE_en), .wM_en(wM_en),
    .wE_dst(wE_dst), .wM_dst(wM_dst),
    .wE_data(wE_data), .wM_data(wM_data),
    .reg_dump(reg_dump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nhit(input logic [3:0] r);
    return int'(wE_en && wE_dst == r) + int'(wM_en && wM_dst == r);
  endfunction

  function automatic logic [DW-1:0] m_val(input logic [3:0] s);
    if (int'(s) >= NR) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wM_en && wM_dst == s) return wM_data;
    if (wE_en && wE_dst == s) return wE_data;
`endif
    return mreg[s];
  endfunction

  function automatic logic m_haz(input logic [3:0] s);
    if (int'(s) >= NR) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    return (mcnt[s] - nhit(s)) > 0;
`else
    return mcnt[s] > 0;
`endif
  endfunction

  function automatic logic m_ready();
    logic r;
    r = 1'b1;
    if (int'(alloc_dstE) < NR && mcnt[alloc_dstE] == CMAX && nhit(alloc_dstE) == 0)
      r = 1'b0;
    if (int'(alloc_dstM) < NR && mcnt[alloc_dstM] == CMAX && nhit(alloc_dstM) == 0)
      r = 1'b0;
    return r;
  endfunction

  function automatic logic [NR*DW-1:0] m_dump();
    logic [NR*DW-1:0] d;
    for (int i = 0; i < NR; i++) d[i*DW +: DW] = mreg[i];
    return d;
  endfunction

  function automatic logic [NR*DW-1:0] rst_dump();
    logic [NR*DW-1:0] d;
    for (int i = 0; i < NR; i++) d[i*DW +: DW] = DW'(i);
    return d;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      mreg[i] = DW'(i);
      mcnt[i] = 0;
    end
  endtask

  task automatic idle();
    srcA = 4'hF; srcB = 4'hF;
    alloc_valid = 1'b0; alloc_dstE = 4'hF; alloc_dstM = 4'hF;
    wE_en = 1'b0; wM_en = 1'b0;
    wE_dst = 4'hF; wM_dst = 4'hF;
    wE_data = '0; wM_data = '0;
  endtask

  // Advance one clock: model next state from the inputs held across the edge
  task automatic tick();
    logic [DW-1:0] nreg [NR];
    int ncnt [NR];
    logic acc;
    acc = alloc_valid && m_ready();
    for (int r = 0; r < NR; r++) begin
      nreg[r] = mreg[r];
      ncnt[r] = mcnt[r] - nhit(4'(r));
      if (acc && (int'(alloc_dstE) == r || int'(alloc_dstM) == r))
        ncnt[r] = ncnt[r] + 1;
      if (ncnt[r] < 0) ncnt[r] = 0;
    end
    if (wE_en && int'(wE_dst) < NR) nreg[wE_dst] = wE_data;
    if (wM_en && int'(wM_dst) < NR) nreg[wM_dst] = wM_data;
    @(posedge clk);
    for (int r = 0; r < NR; r++) begin
      mreg[r] = nreg[r];
      mcnt[r] = ncnt[r];
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    alloc_valid = 1'b1; alloc_dstE = 4'd4;
    wE_en = 1'b1; wE_dst = 4'd4; wE_data = 64'hDEAD;
    tick();
    idle();
    srcA = 4'd4; srcB = 4'd4;
    rst_n = 1'b0;
    m_reset();
    #1;
    if (reg_dump !== rst_dump()) begin
      $display("FAIL reset_dump got %h want %h", reg_dump, rst_dump()); n_err++;
    end
    n_vec++;
    if (valA !== 64'd4) begin
      $display("FAIL reset_valA got %h want 4", valA); n_err++;
    end
    n_vec++;
    if (hazA !== 1'b0 || hazB !== 1'b0) begin
      $display("FAIL reset_haz got %b%b want 00", hazA, hazB); n_err++;
    end
    n_vec++;
    if (alloc_ready !== 1'b1) begin
      $display("FAIL reset_ready got %b want 1", alloc_ready); n_err++;
    end
    n_vec++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    if (reg_dump !== rst_dump() || valA !== 64'd4) begin
      $display("FAIL reset_release got valA %h want 4", valA); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_collision();
    do_reset();
    alloc_valid = 1'b1; alloc_dstE = 4'd4;
    tick();
    idle();
    wE_en = 1'b1; wE_dst = 4'd4; wE_data = 64'h100;
    wM_en = 1'b1; wM_dst = 4'd4; wM_data = 64'h200;
    srcA = 4'd4;
    #1;
    if (hazA !== m_haz(4'd4) || valA !== m_val(4'd4)) begin
      $display("FAIL coll_same_cycle got %b/%h want %b/%h",
               hazA, valA, m_haz(4'd4), m_val(4'd4)); n_err++;
    end
    n_vec++;
    tick();
    idle();
    srcA = 4'd4;
    #1;
    if (valA !== 64'h200) begin
      $display("FAIL coll_m_wins got %h want 200", valA); n_err++;
    end
    n_vec++;
    if (hazA !== 1'b0) begin
      $display("FAIL coll_floor got %b want 0", hazA); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_roundtrip();
    do_reset();
    alloc_valid = 1'b1; alloc_dstE = 4'd3;
    tick();
    idle();
    srcA = 4'd3;
    #1;
    if (hazA !== 1'b1) begin
      $display("FAIL rt_haz_set got %b want 1", hazA); n_err++;
    end
    n_vec++;
    wE_en = 1'b1; wE_dst = 4'd3; wE_data = 64'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    if (hazA !== 1'b0 || valA !== 64'h55) begin
      $display("FAIL rt_bypass got %b/%h want 0/55", hazA, valA); n_err++;
    end
`else
    if (hazA !== 1'b1 || valA !== 64'd3) begin
      $display("FAIL rt_nobypass got %b/%h want 1/3", hazA, valA); n_err++;
    end
`endif
    n_vec++;
    tick();
    idle();
    srcA = 4'd3;
    #1;
    if (hazA !== 1'b0 || valA !== 64'h55) begin
      $display("FAIL rt_after got %b/%h want 0/55", hazA, valA); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      alloc_valid = 1'b1; alloc_dstE = 4'd2; alloc_dstM = 4'hF;
      #1;
      if (alloc_ready !== 1'b1) begin
        $display("FAIL sat_fill%0d got %b want 1", k, alloc_ready); n_err++;
      end
      n_vec++;
      tick();
    end
    #1;
    if (alloc_ready !== 1'b0) begin
      $display("FAIL sat_full got %b want 0", alloc_ready); n_err++;
    end
    n_vec++;
    tick();
    wE_en = 1'b1; wE_dst = 4'd2; wE_data = 64'h77;
    #1;
    if (alloc_ready !== 1'b1) begin
      $display("FAIL sat_relief got %b want 1", alloc_ready); n_err++;
    end
    n_vec++;
    tick();
    for (int k = 0; k < 3; k++) begin
      idle();
      wE_en = 1'b1; wE_dst = 4'd2; wE_data = 64'(k);
      tick();
      idle();
      srcA = 4'd2;
      #1;
      if (hazA !== (k < 2)) begin
        $display("FAIL sat_drain%0d got %b want %b", k, hazA, k < 2); n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_alloc_write();
    do_reset();
    alloc_valid = 1'b1; alloc_dstE = 4'd5;
    tick();
    wE_en = 1'b1; wE_dst = 4'd5; wE_data = 64'hABC;
    #1;
    if (alloc_ready !== 1'b1) begin
      $display("FAIL aw_ready got %b want 1", alloc_ready); n_err++;
    end
    n_vec++;
    tick();
    idle();
    srcB = 4'd5;
    #1;
    if (hazB !== 1'b1 || valB !== 64'hABC) begin
      $display("FAIL aw_result got %b/%h want 1/abc", hazB, valB); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_rnone();
    logic any;
    do_reset();
    wE_en = 1'b1; wE_dst = 4'hF; wE_data = 64'h1111;
    wM_en = 1'b1; wM_dst = 4'hF; wM_data = 64'h2222;
    alloc_valid = 1'b1;
    srcA = 4'hF;
    #1;
    if (valA !== '0 || hazA !== 1'b0 || alloc_ready !== 1'b1) begin
      $display("FAIL rnone_read got %h/%b/%b want 0/0/1", valA, hazA, alloc_ready);
      n_err++;
    end
    n_vec++;
    tick();
    idle();
    #1;
    if (reg_dump !== rst_dump()) begin
      $display("FAIL rnone_regs got %h want %h", reg_dump, rst_dump()); n_err++;
    end
    n_vec++;
    any = 1'b0;
    for (int r = 0; r < NR; r++) begin
      srcA = 4'(r);
      #1;
      any = any | hazA;
    end
    if (any !== 1'b0) begin
      $display("FAIL rnone_counts got %b want 0", any); n_err++;
    end
    n_vec++;
  endtask

  function automatic logic [3:0] rnd_reg();
    int r;
    r = $urandom_range(0, 7);
    return (r == 7) ? 4'hF : 4'(r);
  endfunction

  task automatic test_random(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      srcA = 4'($urandom_range(0, 15));
      srcB = rnd_reg();
      alloc_valid = 1'($urandom);
      alloc_dstE = rnd_reg();
      alloc_dstM = rnd_reg();
      wE_en = 1'($urandom_range(0, 2) == 0);
      wM_en = 1'($urandom_range(0, 2) == 0);
      wE_dst = rnd_reg();
      wM_dst = ($urandom_range(0, 3) == 0) ? wE_dst : rnd_reg();
      wE_data = {$urandom, $urandom};
      wM_data = {$urandom, $urandom};
      #1;
      if (valA !== m_val(srcA) || valB !== m_val(srcB)) begin
        $display("FAIL rnd_val c%0d got %h/%h want %h/%h",
                 c, valA, valB, m_val(srcA), m_val(srcB)); n_err++;
      end
      n_vec++;
      if (hazA !== m_haz(srcA) || hazB !== m_haz(srcB)) begin
        $display("FAIL rnd_haz c%0d got %b%b want %b%b",
                 c, hazA, hazB, m_haz(srcA), m_haz(srcB)); n_err++;
      end
      n_vec++;
      if (alloc_ready !== m_ready()) begin
        $display("FAIL rnd_ready c%0d got %b want %b", c, alloc_ready, m_ready());
        n_err++;
      end
      n_vec++;
      if (reg_dump !== m_dump()) begin
        $display("FAIL rnd_dump c%0d got %h want %h", c, reg_dump, m_dump());
        n_err++;
      end
      n_vec++;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    do_reset();
    test_random(150);
    test_reset();
    test_collision();
    test_roundtrip();
    test_saturation();
    test_alloc_write();
    test_rnone();
    test_random(150);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
